// File: rtl/uart_tx_arbiter_if.sv
// rtl/uart_tx_arbiter_if.sv - requester/transmitter signal bundle for uart_tx_arbiter
// req_lock exists only when UART_ARB_LOCK_EN is defined.
interface uart_tx_arbiter_if #(
  parameter int NREQ = 4
);
  logic [NREQ-1:0]   req;
  logic [8*NREQ-1:0] req_data;
`ifdef UART_ARB_LOCK_EN
  logic [NREQ-1:0]   req_lock;
`endif
  logic [NREQ-1:0]   grant;
  logic [NREQ-1:0]   done;
  logic              err;
  logic              busy;
  logic              tx_ce;
  logic              tx_start;
  logic [7:0]        tx_data;
  logic              tx_busy;
  logic              tx_ack;

`ifdef UART_ARB_LOCK_EN
  modport master (
    input  req, req_data, req_lock, tx_busy, tx_ack,
    output grant, done, err, busy, tx_ce, tx_start, tx_data
  );
  modport slave (
    output req, req_data, req_lock, tx_busy, tx_ack,
    input  grant, done, err, busy, tx_ce, tx_start, tx_data
  );
`else
  modport master (
    input  req, req_data, tx_busy, tx_ack,
    output grant, done, err, busy, tx_ce, tx_start, tx_data
  );
  modport slave (
    output req, req_data, tx_busy, tx_ack,
    input  grant, done, err, busy, tx_ce, tx_start, tx_data
  );
`endif
endinterface

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin sharing of one UART transmitter with no-ack watchdog
// Optional UART_ARB_LOCK_EN: owner keeps the rr pointer on ack while its req_lock is high.
module uart_tx_arbiter #(
  parameter int NREQ           = 4,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input logic               clk,
  input logic               rst,
  uart_tx_arbiter_if.master bus
);
  localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int WDW  = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ISSUE   = 2'd1;
  localparam logic [1:0] S_WAIT    = 2'd2;
  localparam logic [1:0] S_RELEASE = 2'd3;

  logic [1:0]      state_q, state_d;
  logic [IDXW-1:0] rr_q, rr_d;
  logic [IDXW-1:0] owner_q, owner_d;
  logic [WDW-1:0]  wdog_q, wdog_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic [NREQ-1:0] done_q, done_d;
  logic            err_q, err_d;
  logic            busy_q, busy_d;
  logic            ce_q, ce_d;
  logic            start_q, start_d;
  logic [7:0]      data_q, data_d;

  logic            win_found;
  logic [IDXW-1:0] win_idx;
  logic [IDXW-1:0] cand_idx;
  logic [7:0]      win_data;
  logic [NREQ-1:0] win_oh;
  logic [IDXW-1:0] next_ptr;
  logic            keep_ptr;
  int              cand;

  // Scan from the rr pointer upward, wrapping, and take the first requester.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    cand_idx  = '0;
    for (int i = 0; i < NREQ; i++) begin
      cand = int'(rr_q) + i;
      if (cand >= NREQ) cand = cand - NREQ;
      cand_idx = IDXW'(cand);
      if (!win_found && bus.req[cand_idx]) begin
        win_found = 1'b1;
        win_idx   = cand_idx;
      end
    end
  end

  always_comb begin
    win_data = 8'h00;
    for (int i = 0; i < NREQ; i++) begin
      if (win_idx == IDXW'(i)) win_data = bus.req_data[8*i +: 8];
    end
  end

  assign win_oh   = {{(NREQ-1){1'b0}}, 1'b1} << win_idx;
  assign next_ptr = (owner_q == IDXW'(NREQ-1)) ? '0 : owner_q + 1'b1;

`ifdef UART_ARB_LOCK_EN
  assign keep_ptr = bus.req_lock[owner_q];
`else
  assign keep_ptr = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    owner_d = owner_q;
    wdog_d  = wdog_q;
    grant_d = grant_q;
    done_d  = '0;
    err_d   = 1'b0;
    ce_d    = ce_q;
    start_d = 1'b0;
    data_d  = data_q;
    case (state_q)
      S_IDLE: begin
        grant_d = '0;
        ce_d    = 1'b0;
        if (win_found && !bus.tx_busy) begin
          owner_d = win_idx;
          data_d  = win_data;
          grant_d = win_oh;
          ce_d    = 1'b1;
          start_d = 1'b1;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        wdog_d = wdog_q + 1'b1;
        // Ack is checked first so a same-cycle ack beats the watchdog.
        if (bus.tx_ack) begin
          done_d  = grant_q;
          rr_d    = keep_ptr ? owner_q : next_ptr;
          grant_d = '0;
          ce_d    = 1'b0;
          state_d = S_RELEASE;
        end else if (wdog_q == WDW'(TIMEOUT_CYCLES - 1)) begin
          err_d   = 1'b1;
          rr_d    = next_ptr;
          grant_d = '0;
          ce_d    = 1'b0;
          state_d = S_RELEASE;
        end
      end
      S_RELEASE: begin
        wdog_d  = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      rr_q    <= '0;
      owner_q <= '0;
      wdog_q  <= '0;
      grant_q <= '0;
      done_q  <= '0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      ce_q    <= 1'b0;
      start_q <= 1'b0;
      data_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      owner_q <= owner_d;
      wdog_q  <= wdog_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      ce_q    <= ce_d;
      start_q <= start_d;
      data_q  <= data_d;
    end
  end

  assign bus.grant    = grant_q;
  assign bus.done     = done_q;
  assign bus.err      = err_q;
  assign bus.busy     = busy_q;
  assign bus.tx_ce    = ce_q;
  assign bus.tx_start = start_q;
  assign bus.tx_data  = data_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - scoreboard bench for uart_tx_arbiter with a transmitter model
// Lock-mode vectors run only when UART_ARB_LOCK_EN is defined.
module tb_uart_tx_arbiter;
  localparam int NREQ = 4;
  localparam int T    = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.NREQ(NREQ)) ifc();

  uart_tx_arbiter #(.NREQ(NREQ), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk),
    .rst(rst),
    .bus(ifc)
  );

  typedef struct {
    logic [3:0] grant;
    logic [7:0] data;
    bit         is_err;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   ack_cyc = 0;
  int   start_cyc = 0;

  // Transmitter model: ack after ack_n cycles of ce high, busy until ce drops.
  int   ack_n = 3;
  bit   no_ack = 1'b0;
  bit   force_busy = 1'b0;
  bit   m_busy = 1'b0;
  bit   m_acked = 1'b0;
  int   m_cnt = 0;
  logic m_ack = 1'b0;

  assign ifc.tx_busy = m_busy | force_busy;
  assign ifc.tx_ack  = m_ack;

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    m_ack <= 1'b0;
    if (ifc.tx_start) begin
      m_busy  <= 1'b1;
      m_acked <= 1'b0;
      m_cnt   <= 0;
    end else if (!ifc.tx_ce) begin
      m_busy  <= 1'b0;
      m_acked <= 1'b0;
    end else if (m_busy && !m_acked) begin
      if (!no_ack && m_cnt == ack_n - 1) begin
        m_ack   <= 1'b1;
        m_acked <= 1'b1;
      end
      m_cnt <= m_cnt + 1;
    end
  end

  task automatic chk(input bit ok, input string name, input int act, input int expv);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  task automatic push(input logic [3:0] g, input logic [7:0] d, input bit e);
    exp_t x;
    x.grant  = g;
    x.data   = d;
    x.is_err = e;
    exp_q.push_back(x);
  endtask

  // Monitor: compares DUT activity against the head of the scoreboard queue.
  always @(negedge clk) begin
    if (!rst) begin
      if (ifc.tx_ack) ack_cyc = cyc;
      if (ifc.tx_start) begin
        chk(exp_q.size() != 0, "start_expected", exp_q.size(), 1);
        if (exp_q.size() != 0) begin
          chk(ifc.grant == exp_q[0].grant, "start_grant", ifc.grant, exp_q[0].grant);
          chk(ifc.tx_data == exp_q[0].data, "start_data", ifc.tx_data, exp_q[0].data);
        end
        start_cyc = cyc;
      end
      if (ifc.done != 4'b0 || ifc.err) begin
        chk(exp_q.size() != 0, "end_expected", exp_q.size(), 1);
        if (exp_q.size() != 0) begin
          exp_t e;
          e = exp_q.pop_front();
          chk(ifc.done == (e.is_err ? 4'b0 : e.grant), "end_done", ifc.done, e.is_err ? 0 : e.grant);
          chk(ifc.err == e.is_err, "end_err", ifc.err, e.is_err);
          chk(ifc.tx_ce == 1'b0 && ifc.grant == 4'b0, "end_ce_low", {ifc.tx_ce, ifc.grant}, 0);
          if (e.is_err) chk(cyc - start_cyc == T + 1, "err_latency", cyc - start_cyc, T + 1);
          else chk(cyc == ack_cyc + 1, "done_latency", cyc - ack_cyc, 1);
        end
      end
      if ($countones(ifc.grant) > 1 || (ifc.done != 4'b0 && ifc.err))
        chk(1'b0, "invariant", {ifc.grant, ifc.done, ifc.err}, 0);
    end
  end

  task automatic wait_ends(input int n);
    int seen;
    int budget;
    seen = 0;
    budget = 0;
    while (seen < n && budget < 400 * n) begin
      @(negedge clk);
      budget++;
      if (ifc.done != 4'b0 || ifc.err) seen++;
    end
    chk(seen == n, "wait_ends", seen, n);
  endtask

  task automatic pulse_reset();
    exp_q.delete();
    rst = 1'b1;
    @(negedge clk);
    chk({ifc.grant, ifc.done, ifc.err, ifc.busy, ifc.tx_ce, ifc.tx_start, ifc.tx_data} == 20'h0,
        "reset_outputs",
        {ifc.grant, ifc.done, ifc.err, ifc.busy, ifc.tx_ce, ifc.tx_start, ifc.tx_data}, 0);
    rst = 1'b0;
  endtask

  initial begin
    int starts;
    ifc.req      = 4'b0;
    ifc.req_data = {8'h44, 8'h33, 8'h22, 8'h11};
`ifdef UART_ARB_LOCK_EN
    ifc.req_lock = 4'b0;
`endif
    @(negedge clk);
    pulse_reset();
    @(negedge clk);

    // Single requester 1, one-cycle issue latency
    ifc.req_data = {8'h44, 8'h33, 8'hA5, 8'h11};
    push(4'b0010, 8'hA5, 1'b0);
    ifc.req = 4'b0010;
    @(negedge clk);
    chk(ifc.tx_start == 1'b1, "issue_latency", ifc.tx_start, 1);
    wait_ends(1);
    ifc.req = 4'b0;
    ifc.req_data = {8'h44, 8'h33, 8'h22, 8'h11};

    // Contention from reset pointer: 0,1,2,3,0
    pulse_reset();
    push(4'b0001, 8'h11, 1'b0);
    push(4'b0010, 8'h22, 1'b0);
    push(4'b0100, 8'h33, 1'b0);
    push(4'b1000, 8'h44, 1'b0);
    push(4'b0001, 8'h11, 1'b0);
    ifc.req = 4'b1111;
    wait_ends(5);
    ifc.req = 4'b0;

    // Pointer now 1; a lone byte from 2 moves it to 3, then 1001 wraps 3 -> 0
    push(4'b0100, 8'h33, 1'b0);
    ifc.req = 4'b0100;
    wait_ends(1);
    ifc.req = 4'b0;
    push(4'b1000, 8'h44, 1'b0);
    push(4'b0001, 8'h11, 1'b0);
    ifc.req = 4'b1001;
    wait_ends(2);
    ifc.req = 4'b0;
    for (int i = 0; i < 3; i++) push(4'b0001, 8'h11, 1'b0);
    ifc.req = 4'b0001;
    wait_ends(3);
    ifc.req = 4'b0;

    // Watchdog abort
    no_ack = 1'b1;
    push(4'b0001, 8'h11, 1'b1);
    ifc.req = 4'b0001;
    wait_ends(1);
    ifc.req = 4'b0;
    no_ack = 1'b0;

    // Ack lands on the same cycle the watchdog would fire: ack wins
    ack_n = T - 1;
    push(4'b0001, 8'h11, 1'b0);
    ifc.req = 4'b0001;
    wait_ends(1);
    ifc.req = 4'b0;
    ack_n = 3;

    // Reset while in WAIT_ACK with transmitter busy
    no_ack = 1'b1;
    push(4'b0010, 8'h22, 1'b0);
    ifc.req = 4'b0010;
    @(negedge clk);
    @(negedge clk);
    force_busy = 1'b1;
    pulse_reset();
    no_ack = 1'b0;
    push(4'b0010, 8'h22, 1'b0);
    starts = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (ifc.tx_start) starts++;
    end
    chk(starts == 0, "no_start_while_busy", starts, 0);
    force_busy = 1'b0;
    wait_ends(1);
    ifc.req = 4'b0;

`ifdef UART_ARB_LOCK_EN
    // Locked owner 0 keeps three bytes, then requester 1
    pulse_reset();
    push(4'b0001, 8'h11, 1'b0);
    push(4'b0001, 8'h11, 1'b0);
    push(4'b0001, 8'h11, 1'b0);
    push(4'b0010, 8'h22, 1'b0);
    ifc.req_lock = 4'b0001;
    ifc.req = 4'b0011;
    wait_ends(2);
    ifc.req_lock = 4'b0;
    wait_ends(2);
    ifc.req = 4'b0;
`endif

    repeat (4) @(negedge clk);
    chk(exp_q.size() == 0, "queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
